// File: rtl/led_pkg.sv
// Shared constants for the multiplexed seven-segment driver: active-low
// segment table ({a,b,c,d,e,f,g}, a = bit 6), the all-off code and slot states.
package led_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,   // 0 1 2 3
        7'h4C, 7'h24, 7'h20, 7'h0F,   // 4 5 6 7
        7'h00, 7'h04, 7'h08, 7'h60,   // 8 9 A b
        7'h31, 7'h42, 7'h30, 7'h38    // C d E F
    };

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment code.
module hex_seg_decoder
    import led_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // table lookup, one entry per hex value
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/multi_digit_led_driver.sv
// Time-multiplexed NUM_DIGITS seven-segment driver with anti-ghost blanking
// and a double-buffered frame interface. Optional rotation: LED_SCROLL_EN.
module multi_digit_led_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 1024,
    parameter int ON_TICKS      = 4,
    parameter int BLANK_TICKS   = 1,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] frame_data,
    input  logic [NUM_DIGITS-1:0]   frame_dp,
    input  logic [NUM_DIGITS-1:0]   frame_blank,
    input  logic                    frame_valid,
`ifdef LED_SCROLL_EN
    input  logic                    scroll,
`endif
    output logic                    frame_ready,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int SLOT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int SLOT_W   = (SLOT_MAX < 2) ? 1 : $clog2(SLOT_MAX);
    localparam int IDX_W    = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [SLOT_W-1:0] ON_LAST    = SLOT_W'(ON_TICKS - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W:0]    NUM_EXT    = (IDX_W+1)'(NUM_DIGITS);
    localparam slot_state_e ST_RESET = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;
    localparam slot_state_e ST_AFTER = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || TICK_DIV < 2 || ON_TICKS < 1 ||
        BLANK_TICKS < 0 || SCROLL_FRAMES < 1) begin : g_bad_params
        $error("multi_digit_led_driver: parameter out of range");
    end

    logic [PRE_W-1:0]        pre_r;
    logic [SLOT_W-1:0]       slot_r;
    logic [IDX_W-1:0]        idx_r;
    slot_state_e             state_r;
    logic [4*NUM_DIGITS-1:0] act_data_r, pend_data_r;
    logic [NUM_DIGITS-1:0]   act_dp_r, act_blank_r, pend_dp_r, pend_blank_r;
    logic                    pend_r, frame_ready_r, frame_done_r, dp_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;

    logic                    tick_s, show_end_s, boundary_s, capture_s, lit_s, dp_s;
    logic [IDX_W-1:0]        offset_s, sel_s;
    logic [IDX_W:0]          sum_s, wrap_s;
    logic [3:0]              nibble_s;
    logic [6:0]              dec_seg_s, seg_s;
    logic [NUM_DIGITS-1:0]   an_s;

    // slot timing, handshake strobes and the digit actually being shown
    always_comb begin
        tick_s     = (pre_r == PRE_LAST);
        show_end_s = tick_s && (state_r == ST_SHOW) && (slot_r == ON_LAST);
        boundary_s = show_end_s && (idx_r == IDX_LAST);
        capture_s  = frame_valid && frame_ready_r;
        sum_s      = {1'b0, idx_r} + {1'b0, offset_s};
        wrap_s     = sum_s - NUM_EXT;
        sel_s      = (sum_s >= NUM_EXT) ? wrap_s[IDX_W-1:0] : sum_s[IDX_W-1:0];
        nibble_s   = act_data_r[{sel_s, 2'b00} +: 4];
        lit_s      = (state_r == ST_SHOW) && !act_blank_r[sel_s];
        seg_s      = lit_s ? dec_seg_s : SEG_OFF;
        dp_s       = lit_s ? ~act_dp_r[sel_s] : 1'b1;
        an_s       = (state_r == ST_SHOW) ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r)
                                          : {NUM_DIGITS{1'b1}};
    end

    hex_seg_decoder u_dec (
        .nibble (nibble_s),
        .seg    (dec_seg_s)
    );

`ifdef LED_SCROLL_EN
    localparam int SCR_W = (SCROLL_FRAMES < 2) ? 1 : $clog2(SCROLL_FRAMES);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_FRAMES - 1);

    logic [SCR_W-1:0] scr_cnt_r;
    logic [IDX_W-1:0] offset_r;

    // rotation offset steps once every SCROLL_FRAMES boundaries while scrolling
    always_ff @(posedge clk) begin
        if (!reset) begin
            scr_cnt_r <= '0;
            offset_r  <= '0;
        end else if (boundary_s && scroll) begin
            if (scr_cnt_r == SCR_LAST) begin
                scr_cnt_r <= '0;
                offset_r  <= (offset_r == IDX_LAST) ? '0 : offset_r + 1'b1;
            end else begin
                scr_cnt_r <= scr_cnt_r + 1'b1;
            end
        end
    end

    assign offset_s = offset_r;
`else
    assign offset_s = '0;
`endif

    // prescaler and blank/show slot sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_r   <= '0;
            slot_r  <= '0;
            idx_r   <= '0;
            state_r <= ST_RESET;
        end else begin
            pre_r <= tick_s ? '0 : pre_r + 1'b1;
            if (tick_s) begin
                case (state_r)
                    ST_BLANK: begin
                        if (slot_r == BLANK_LAST) begin
                            slot_r  <= '0;
                            state_r <= ST_SHOW;
                        end else begin
                            slot_r <= slot_r + 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (slot_r == ON_LAST) begin
                            slot_r  <= '0;
                            idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + 1'b1;
                            state_r <= ST_AFTER;
                        end else begin
                            slot_r <= slot_r + 1'b1;
                        end
                    end
                    default: begin
                        slot_r  <= '0;
                        state_r <= ST_RESET;
                    end
                endcase
            end
        end
    end

    // double buffer: capture into pending, promote to active only at a frame boundary
    always_ff @(posedge clk) begin
        if (!reset) begin
            act_data_r    <= '0;
            act_dp_r      <= '0;
            act_blank_r   <= '1;
            pend_data_r   <= '0;
            pend_dp_r     <= '0;
            pend_blank_r  <= '1;
            pend_r        <= 1'b0;
            frame_ready_r <= 1'b1;
        end else if (boundary_s && pend_r) begin
            act_data_r    <= pend_data_r;
            act_dp_r      <= pend_dp_r;
            act_blank_r   <= pend_blank_r;
            pend_r        <= 1'b0;
            frame_ready_r <= 1'b1;
        end else if (capture_s) begin
            pend_data_r   <= frame_data;
            pend_dp_r     <= frame_dp;
            pend_blank_r  <= frame_blank;
            pend_r        <= 1'b1;
            frame_ready_r <= 1'b0;
        end
    end

    // pin registers, one cycle behind the sequencer
    always_ff @(posedge clk) begin
        if (!reset) begin
            an_r         <= '1;
            seg_r        <= SEG_OFF;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            frame_done_r <= boundary_s;
        end
    end

    assign frame_ready = frame_ready_r;
    assign an          = an_r;
    assign seg         = seg_r;
    assign dp          = dp_r;
    assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// Self-checking bench: per-cycle time-arithmetic reference model plus vector
// table and directed sequences. Scroll checks compile in with LED_SCROLL_EN.
module tb_multi_digit_led_driver;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ON = 2;
    localparam int BL = 1;
    localparam int SF = 2;
    localparam int P  = ON + BL;
    localparam int FRAME_CYC = TD * N * P;
`ifdef LED_SCROLL_EN
    localparam bit HAS_SCROLL = 1'b1;
`else
    localparam bit HAS_SCROLL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] frame_data = '0;
    logic [3:0]  frame_dp = '0, frame_blank = '0;
    logic        frame_valid = 1'b0;
    logic        scroll_v = 1'b0;
    logic        frame_ready, dp, frame_done;
    logic [3:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    multi_digit_led_driver #(
        .NUM_DIGITS(N), .TICK_DIV(TD), .ON_TICKS(ON), .BLANK_TICKS(BL), .SCROLL_FRAMES(SF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_dp    (frame_dp),
        .frame_blank (frame_blank),
        .frame_valid (frame_valid),
`ifdef LED_SCROLL_EN
        .scroll      (scroll_v),
`endif
        .frame_ready (frame_ready),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_done  (frame_done)
    );

    // Reference segment code built from the list of lit segments of each glyph.
    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        string lit;
        logic [6:0] s;
        int k;
        case (v)
            4'h0: lit = "abcdef";  4'h1: lit = "bc";
            4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
            4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
            4'h6: lit = "acdefg";  4'h7: lit = "abc";
            4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
            4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
            4'hC: lit = "adef";    4'hD: lit = "bcdeg";
            4'hE: lit = "adefg";   default: lit = "aefg";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) begin
            k = int'(lit[i]) - 97;
            s[6 - k] = 1'b0;
        end
        return s;
    endfunction

    // Reference model: position in the scan follows from the number of clock
    // edges since reset; buffers follow the handshake rules.
    int          m_c = 0, m_sb = 0;
    bit          m_live = 1'b0, m_pend = 1'b0;
    logic [15:0] m_ad, m_pd;
    logic [3:0]  m_ap, m_ab, m_pp, m_pb;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_done;

    always @(posedge clk) begin
        int t, ph, dig, off, sel;
        bit show, bnd;
        m_live = 1'b1;
        if (!reset) begin
            m_c = 0; m_sb = 0; m_pend = 1'b0;
            m_ad = '0; m_ap = '0; m_ab = '1; m_pd = '0; m_pp = '0; m_pb = '1;
            e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_done = 1'b0;
        end else begin
            t    = m_c / TD;
            ph   = t % P;
            dig  = (t / P) % N;
            show = (ph >= BL);
            off  = HAS_SCROLL ? (m_sb / SF) % N : 0;
            sel  = (dig + off) % N;
            e_an = '1;
            if (show) e_an[dig] = 1'b0;
            if (show && !m_ab[sel]) begin
                e_seg = ref_seg(m_ad[sel*4 +: 4]);
                e_dp  = ~m_ap[sel];
            end else begin
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            bnd    = ((m_c + 1) % FRAME_CYC) == 0;
            e_done = bnd;
            if (bnd && m_pend) begin
                m_ad = m_pd; m_ap = m_pp; m_ab = m_pb; m_pend = 1'b0;
            end else if (frame_valid && !m_pend) begin
                m_pd = frame_data; m_pp = frame_dp; m_pb = frame_blank; m_pend = 1'b1;
            end
            if (bnd && scroll_v) m_sb = m_sb + 1;
            m_c = m_c + 1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            n_checks++;
            if ({frame_ready, an, seg, dp, frame_done} !== {~m_pend, e_an, e_seg, e_dp, e_done}) begin
                n_err++;
                $display("FAIL model t=%0t an=%b exp %b seg=%h exp %h dp=%b exp %b done=%b exp %b ready=%b exp %b",
                         $time, an, e_an, seg, e_seg, dp, e_dp, frame_done, e_done, frame_ready, ~m_pend);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bit acc = 1'b0;
        int budget = 200;
        frame_data = d; frame_dp = p; frame_blank = b; frame_valid = 1'b1;
        while (!acc && budget > 0) begin
            acc = frame_ready;
            step(1);
            budget--;
        end
        frame_valid = 1'b0;
        chk("offer_accepted", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int budget = 200;
        while (an !== target && budget > 0) begin
            step(1);
            budget--;
        end
        chk(name, {28'd0, an}, {28'd0, target});
    endtask

    task automatic wait_done(input string name);
        int budget = 200;
        while (frame_done !== 1'b1 && budget > 0) begin
            step(1);
            budget--;
        end
        chk(name, {31'd0, frame_done}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
        logic [6:0]  seg0;
        logic        dp0;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int cnt, bad;
        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 7'h4C, 1'b1};
        tbl[1] = '{16'h00A0, 4'b0001, 4'b0000, 7'h01, 1'b0};
        tbl[2] = '{16'hFFF8, 4'b1110, 4'b0000, 7'h00, 1'b1};
        tbl[3] = '{16'h000B, 4'b0001, 4'b0001, 7'h7F, 1'b1};
        tbl[4] = '{16'h0007, 4'b0000, 4'b1110, 7'h0F, 1'b1};
        tbl[5] = '{16'h555E, 4'b0011, 4'b0000, 7'h30, 1'b0};

        // reset values
        step(3);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_ready", {31'd0, frame_ready}, 32'd1);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        reset = 1'b1;

        // scan timing with 1234
        offer(16'h1234, 4'b0000, 4'b0000);
        wait_done("first_done");
        cnt = 0;
        do begin
            step(1);
            cnt++;
        end while (frame_done !== 1'b1 && cnt < 200);
        chk("frame_period", cnt, FRAME_CYC);
        wait_an(4'b1110, "digit0_lit");
        chk("digit0_seg_1234", {25'd0, seg}, 32'h4C);
        cnt = 0;
        while (an === 4'b1110 && cnt < 50) begin step(1); cnt++; end
        chk("show_len", cnt, 8);
        cnt = 0;
        while (an === 4'b1111 && cnt < 50) begin step(1); cnt++; end
        chk("blank_len", cnt, 4);
        chk("digit1_after_blank", {28'd0, an}, 32'hD);

        // vector table
        for (int i = 0; i < 6; i++) begin
            offer(tbl[i].d, tbl[i].p, tbl[i].b);
            wait_done("tbl_done");
            wait_an(4'b1110, "tbl_digit0");
            chk("tbl_seg0", {25'd0, seg}, {25'd0, tbl[i].seg0});
            chk("tbl_dp0", {31'd0, dp}, {31'd0, tbl[i].dp0});
        end

        // double buffer: second frame stalls until the first is promoted
        wait_an(4'b1011, "db_mid_frame");
        offer(16'hABCD, 4'b0000, 4'b0000);
        frame_data = 16'h0000; frame_valid = 1'b1;
        step(1);
        chk("db_ready_low", {31'd0, frame_ready}, 32'd0);
        wait_done("db_done");
        chk("db_ready_back", {31'd0, frame_ready}, 32'd1);
        step(1);
        frame_valid = 1'b0;
        chk("db_second_captured", {31'd0, frame_ready}, 32'd0);
        wait_an(4'b1110, "db_digit0");
        chk("db_shows_abcd", {25'd0, seg}, 32'h42);

        // random frames with junk valid pulses while the pending buffer is full
        for (int r = 0; r < 8; r++) begin
            step($urandom_range(0, 40));
            offer(16'($urandom), 4'($urandom), 4'($urandom));
            for (int k = 0; k < int'($urandom_range(5, 20)); k++) begin
                frame_valid = 1'($urandom);
                frame_data  = 16'($urandom);
                frame_dp    = 4'($urandom);
                frame_blank = 4'($urandom);
                step(1);
            end
            frame_valid = 1'b0;
        end

        // blank and decimal-point handling
        offer(16'h1234, 4'b0001, 4'b0100);
        wait_done("bd_done");
        while (frame_ready !== 1'b1) step(1);
        wait_done("bd_done2");
        wait_an(4'b1110, "bd_digit0");
        chk("bd_dp0_lit", {31'd0, dp}, 32'd0);
        wait_an(4'b1011, "bd_digit2");
        chk("bd_digit2_dark", {25'd0, seg}, 32'h7F);

        // reset mid-SHOW of digit 2 with a frame pending
        step(2);
        offer(16'h5555, 4'b1111, 4'b0000);
        chk("mid_pending", {31'd0, frame_ready}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst_ready", {31'd0, frame_ready}, 32'd1);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < FRAME_CYC + 12; k++) begin
            if (seg !== 7'h7F || dp !== 1'b1) bad++;
            step(1);
        end
        chk("dark_after_reset", bad, 0);

`ifdef LED_SCROLL_EN
        // rotation: model tracks offset across nine frames
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        scroll_v = 1'b1;
        offer(16'h1234, 4'b0001, 4'b0000);
        step(FRAME_CYC * 9);
        scroll_v = 1'b0;
        step(FRAME_CYC * 2);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
